// File: rtl/pp_matrix_loader.sv
// Serial loader for the triangular partial-product matrix of an N x N multiplier.
// Beats shift one bit into each column; FRAME mode captures every N beats, STREAM exposes live bits.
module pp_matrix_loader #(
   parameter int N = 25
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*N-2:0]     in_bits,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*N-1:0]     out_mat
);

   localparam int C     = 2*N-1;
   localparam int TOT   = N*N;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

   function automatic int col_h(input int c);
      return (c + 1 < 2*N-1-c) ? c + 1 : 2*N-1-c;
   endfunction

   function automatic int col_off(input int c);
      if (c < N) return c*(c+1)/2;
      return N*N - (2*N-1-c)*(2*N-c)/2;
   endfunction

   logic [TOT-1:0]   sr_q;
   wire  [TOT-1:0]   sr_d;
   logic [TOT-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic             filled_q, filled_d;
   logic             mode_q;
   logic             acc, chg, last, wrap;

   assign last     = (cnt_q == CNT_LAST);
   assign chg      = (mode != mode_q);
   assign in_ready = ~rst & (mode_q | ~last | ~vld_q | out_ready);
   assign acc      = in_valid & in_ready;
   // A beat landing in the mode-change cycle is shifted in but never completes a frame.
   assign wrap     = acc & last & ~chg;

   for (genvar c = 0; c < C; c++) begin : g_col
      localparam int H = col_h(c);
      localparam int O = col_off(c);
      if (H == 1) begin : g_one
         assign sr_d[O] = acc ? in_bits[c] : sr_q[O];
      end else begin : g_sh
         assign sr_d[O +: H] = acc ? {sr_q[O +: H-1], in_bits[c]} : sr_q[O +: H];
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      vld_d    = vld_q;
      filled_d = filled_q;
      hold_d   = hold_q;
      if (chg) begin
         cnt_d    = '0;
         vld_d    = 1'b0;
         filled_d = 1'b0;
      end else begin
         if (acc) cnt_d = last ? '0 : cnt_q + 1'b1;
         if (mode_q) begin
            if (wrap) filled_d = 1'b1;
         end else if (wrap) begin
            hold_d = sr_d;
            vld_d  = 1'b1;
         end else if (vld_q & out_ready) begin
            vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q     <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
         filled_q <= 1'b0;
         mode_q   <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         filled_q <= filled_d;
         mode_q   <= mode;
      end
   end

   assign out_valid = mode_q ? filled_q : vld_q;
   assign out_mat   = mode_q ? sr_q : hold_q;

endmodule

// File: tb/tb_pp_matrix_loader.sv
// Directed bench for pp_matrix_loader at N=4 (7 columns, 16-bit matrix).
module tb_pp_matrix_loader;

   localparam int N = 4;

   logic          clk;
   logic          rst;
   logic          mode;
   logic          in_valid;
   logic          in_ready;
   logic [2*N-2:0] in_bits;
   logic          out_valid;
   logic          out_ready;
   logic [N*N-1:0] out_mat;

   int n_tests = 0;
   int n_fail  = 0;

   pp_matrix_loader #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mat   (out_mat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2*N-2:0] b);
      chk("rdy_before_beat", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_bits  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_bits  = '0;
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_mat", {16'd0, out_mat}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Frame of 7F,00,00,00: only column 3 still holds beat 1
      send(7'h7F); send(7'h00); send(7'h00);
      chk("f1_vld_early", {31'd0, out_valid}, 32'd0);
      send(7'h00);
      chk("f1_vld", {31'd0, out_valid}, 32'd1);
      chk("f1_mat", {16'd0, out_mat}, 32'h0200);
      @(posedge clk); #1;
      chk("f1_vld_drop", {31'd0, out_valid}, 32'd0);

      // All ones then all zeros
      for (int i = 0; i < 4; i++) send(7'h7F);
      chk("f2_vld", {31'd0, out_valid}, 32'd1);
      chk("f2_mat", {16'd0, out_mat}, 32'hFFFF);
      for (int i = 0; i < 4; i++) send(7'h00);
      chk("f3_vld", {31'd0, out_valid}, 32'd1);
      chk("f3_mat", {16'd0, out_mat}, 32'h0000);

      // Backpressure: frame held, 8th beat stalls until out_ready
      out_ready = 1'b0;
      send(7'h7F); send(7'h7F); send(7'h7F);
      chk("bp_rdy_low", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; in_bits = 7'h00;
      @(posedge clk); #1;
      chk("bp_vld_held", {31'd0, out_valid}, 32'd1);
      chk("bp_mat_held", {16'd0, out_mat}, 32'h0000);
      chk("bp_rdy_still_low", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_release", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_bits = '0;
      chk("bp_vld_kept", {31'd0, out_valid}, 32'd1);
      chk("bp_mat_new", {16'd0, out_mat}, 32'h5BB4);
      @(posedge clk); #1;
      chk("bp_vld_drop", {31'd0, out_valid}, 32'd0);

      // STREAM from a clean reset
      rst = 1'b1; mode = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("st_vld_init", {31'd0, out_valid}, 32'd0);
      chk("st_mat_init", {16'd0, out_mat}, 32'h0000);
      send(7'h01);
      chk("st_mat_b1", {16'd0, out_mat}, 32'h0001);
      chk("st_vld_b1", {31'd0, out_valid}, 32'd0);
      send(7'h00);
      chk("st_mat_b2", {16'd0, out_mat}, 32'h0000);
      send(7'h00);
      chk("st_vld_b3", {31'd0, out_valid}, 32'd0);
      send(7'h00);
      chk("st_vld_b4", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("st_vld_sticky", {31'd0, out_valid}, 32'd1);
      chk("st_rdy_ignores_out_ready", {31'd0, in_ready}, 32'd1);

      // Back to FRAME, then async reset mid-frame
      mode = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("mc_vld_clear", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) send(7'h7F);
      chk("ar_vld_pre", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b0;
      send(7'h7F); send(7'h7F);
      #2 rst = 1'b1;
      #1;
      chk("ar_vld", {31'd0, out_valid}, 32'd0);
      chk("ar_mat", {16'd0, out_mat}, 32'h0000);
      chk("ar_rdy", {31'd0, in_ready}, 32'd0);
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      send(7'h7F); send(7'h7F); send(7'h7F);
      chk("ar_vld_3beats", {31'd0, out_valid}, 32'd0);
      send(7'h7F);
      chk("ar_vld_4beats", {31'd0, out_valid}, 32'd1);
      chk("ar_mat_full", {16'd0, out_mat}, 32'hFFFF);

      // Mode toggle 0->1 at cnt=2; beat in the toggle cycle is not counted
      send(7'h7F); send(7'h7F);
      mode = 1'b1;
      send(7'h7F);
      chk("tg_vld_clear", {31'd0, out_valid}, 32'd0);
      send(7'h7F); send(7'h7F); send(7'h7F);
      chk("tg_vld_3", {31'd0, out_valid}, 32'd0);
      send(7'h7F);
      chk("tg_vld_4", {31'd0, out_valid}, 32'd1);
      chk("tg_mat", {16'd0, out_mat}, 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pp_matrix_loader.md
Name: pp_matrix_loader

Overview:
- Parametrised successor to the fixed 25-bit partial-product shift-register harness. It serially loads the triangular partial-product bit matrix of an N×N multiplier (2N-1 columns) and presents it to a compressor under test.
- Adds a valid/ready handshake, a beat counter, a frame-capture holding register with backpressure, and a runtime streaming mode.
- Sits between the bench stimulus (one bit per column per beat) and the compressor's flattened column inputs.

Parameters:
- N, 25, multiplier operand width; columns C = 2N-1, column height h(c) = min(c+1, 2N-1-c), total bits N*N.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = FRAME (capture every N beats), 1 = STREAM (live matrix)
- in_valid  input  1  beat present on in_bits
- in_ready  output  1  beat can be accepted this cycle
- in_bits  input  2N-1  one new bit per column; bit c feeds column c
- out_valid  output  1  out_mat holds a valid matrix
- out_ready  input  1  consumer accepts out_mat (FRAME mode)
- out_mat  output  N*N  flattened matrix; column c starts at offset off(c); bit off(c)+k is the k-th newest bit of column c

Behaviour:
- Offsets: off(c) = c(c+1)/2 for c < N; off(c) = N*N - (2N-1-c)(2N-c)/2 for c >= N. Both are elaboration-time constants.
- Reset (async, rst=1) clears: all column shift registers sr_c, hold register, cnt, filled, out_valid=0, out_mat=0, mode_q=0.
- in_ready=0 during reset.
- Accept: acc = in_valid & in_ready. On acc, sr_c <= {sr_c[h(c)-2:0], in_bits[c]}: newest bit at index 0, oldest bit dropped. A column with h=1 simply loads in_bits[c].
- cnt: 0..N-1. It increments on acc, wraps to 0 after N-1, and holds otherwise.
- FRAME mode (mode_q=0):
  - in_ready = (cnt != N-1) | ~out_valid | out_ready.
  - On acc with cnt == N-1: hold <= post-shift sr values (includes the current beat), out_valid <= 1, cnt <= 0.
  - On out_valid & out_ready without a capture in the same cycle: out_valid <= 0.
  - Capture and consume in the same cycle: hold updates, out_valid stays 1.
  - out_mat = hold. It is stable while out_valid & ~out_ready.
- STREAM mode (mode_q=1):
  - in_ready = 1.
  - out_mat = live sr values (registered, so it changes the cycle after acc).
  - filled sets on the acc where cnt == N-1 and stays set; out_valid = filled.
  - out_ready is ignored.
- Mode change: mode_q <= mode every cycle. When mode != mode_q, the registered update sets cnt=0, filled=0, out_valid=0. Shift-register contents are kept. A beat accepted in that same cycle is shifted but does not count.
- Latency:
  - FRAME: out_valid rises the cycle after the N-th accepted beat.
  - STREAM: each beat is visible on out_mat one cycle after acceptance.
- Reset mid-frame discards the partial frame. No output glitch beyond the async clear.
- in_bits is ignored when acc=0.

Test Plan:
- N=4 (columns 7, heights 1,2,3,4,3,2,1, out 16 bits), FRAME, out_ready=1. Beats in_bits = 7'h7F, 7'h00, 7'h00, 7'h00 → out_valid for 1 cycle after beat 4, out_mat = 16'h0200 (only column 3 retains beat 1, at bit 6+3).
- N=4, FRAME, four beats of 7'h7F → out_mat = 16'hFFFF. Then four beats of 7'h00 → out_mat = 16'h0000 on the next frame.
- N=4, FRAME, out_ready=0 after the first frame: beats 5–7 accepted, 8th beat sees in_ready=0 and out_mat unchanged. Raise out_ready → beat 8 accepted that cycle, new frame captured, out_valid stays 1.
- N=4, STREAM, beat 7'h01 then 7'h00 → cycle after beat 1 out_mat = 16'h0001. After beat 2 out_mat = 16'h0000 (column 0, h=1). out_valid = 0 until 4 beats total, then stays 1.
- Assert rst asynchronously after 2 beats in FRAME → out_valid=0 and out_mat=0 immediately. After release, a full frame needs 4 fresh beats.
- Toggle mode 0→1 at cnt=2 → cnt cleared, out_valid=0. In STREAM, out_valid rises only after 4 more counted beats.
